// File: rtl/tpu_mc.sv
// tpu_mc: multi-channel time processing unit. A shared prescaled period counter
// feeds N_CH channels, each with a compare flag and TX/RX modulation clock dividers.
module tpu_mc #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned N_CH  = 4
) (
  input  logic            sys_clock,
  input  logic            reset,
  input  logic            valid,
  input  logic [7:0]      addr,
  input  logic [7:0]      data_in,
  output logic [7:0]      data_out,
  output logic [N_CH-1:0] g_clk_tx,
  output logic [N_CH-1:0] g_clk_rx,
  output logic            tpu_int
);
  localparam int unsigned B         = CNT_W / 8;
  localparam logic [3:0]  N_CH4     = 4'(N_CH);
  localparam logic [7:0]  FLAG_MASK = 8'h80 | 8'((1 << N_CH) - 1);

  logic             en, oneshot;
  logic [1:0]       presc;
  logic [2:0]       presc_cnt, mask;
  logic [7:0]       status, inten, set_bits, w1c;
  logic [CNT_W-1:0] period, cnt, count_snap;
  logic [CNT_W-1:0] cmp     [N_CH];
  logic [7:0]       tx_slot [N_CH];
  logic [7:0]       rx_slot [N_CH];
  logic [7:0]       tx_div  [N_CH];
  logic [7:0]       rx_div  [N_CH];
  logic [N_CH-1:0]  ch_en, cmp_hit;
  logic             tick, wrap, wr_ctrl, srst_wr, ch_sel;
  logic [3:0]       ch_idx;

  assign mask     = 3'((4'd1 << presc) - 4'd1);
  assign tick     = en && ((presc_cnt & mask) == mask);
  assign wrap     = tick && (cnt == period);
  assign wr_ctrl  = valid && (addr == 8'h00);
  assign srst_wr  = wr_ctrl && data_in[1];
  assign ch_sel   = (addr[7:4] != 4'd0) && (addr[7:4] <= N_CH4);
  assign ch_idx   = addr[7:4] - 4'd1;
  assign set_bits = {wrap, 7'b0} | 8'(cmp_hit);
  assign w1c      = (valid && addr == 8'h01) ? (data_in & FLAG_MASK) : 8'h00;

  always_comb begin
    cmp_hit = '0;
    for (int unsigned c = 0; c < N_CH; c++)
      cmp_hit[c] = tick && ch_en[c] && (cnt == cmp[c]);
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      en         <= 1'b0;
      oneshot    <= 1'b0;
      presc      <= '0;
      presc_cnt  <= '0;
      status     <= '0;
      inten      <= '0;
      period     <= '0;
      cnt        <= '0;
      count_snap <= '0;
      ch_en      <= '0;
      g_clk_tx   <= '0;
      g_clk_rx   <= '0;
      tpu_int    <= 1'b0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        cmp[c]     <= '0;
        tx_slot[c] <= '0;
        rx_slot[c] <= '0;
        tx_div[c]  <= '0;
        rx_div[c]  <= '0;
      end
    end else begin
      if (wr_ctrl) begin
        en      <= data_in[0];
        presc   <= data_in[3:2];
        oneshot <= data_in[4];
      end else if (wrap && oneshot) begin
        en <= 1'b0;
      end
      if (wr_ctrl && data_in[5]) count_snap <= cnt;
      if (valid && addr == 8'h02) inten <= data_in & FLAG_MASK;
      for (int unsigned i = 0; i < B; i++)
        if (valid && addr == 8'(4 + i)) period[8*i +: 8] <= data_in;

      for (int unsigned c = 0; c < N_CH; c++) begin
        if (valid && ch_sel && ch_idx == 4'(c)) begin
          for (int unsigned i = 0; i < B; i++)
            if (addr[3:0] == 4'(i)) cmp[c][8*i +: 8] <= data_in;
          if (addr[3:0] == 4'h4) tx_slot[c] <= data_in;
          if (addr[3:0] == 4'h5) rx_slot[c] <= data_in;
          if (addr[3:0] == 4'h6) ch_en[c]   <= data_in[0];
        end
        if (srst_wr || !ch_en[c]) begin
          tx_div[c]   <= '0;
          rx_div[c]   <= '0;
          g_clk_tx[c] <= 1'b0;
          g_clk_rx[c] <= 1'b0;
        end else if (tick) begin
          if (tx_div[c] == tx_slot[c]) begin
            tx_div[c]   <= '0;
            g_clk_tx[c] <= ~g_clk_tx[c];
          end else begin
            tx_div[c] <= tx_div[c] + 8'd1;
          end
          if (rx_div[c] == rx_slot[c]) begin
            rx_div[c]   <= '0;
            g_clk_rx[c] <= ~g_clk_rx[c];
          end else begin
            rx_div[c] <= rx_div[c] + 8'd1;
          end
        end
      end

      // SRST overrides the CTRL EN write and any flag set on the same edge
      if (srst_wr) begin
        en        <= 1'b0;
        presc_cnt <= '0;
        cnt       <= '0;
        status    <= '0;
      end else begin
        presc_cnt <= en ? presc_cnt + 3'd1 : 3'd0;
        if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
        status <= (status & ~w1c) | set_bits;
      end
      tpu_int <= |(status & inten);
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      8'h00: data_out = {3'b000, oneshot, presc, 1'b0, en};
      8'h01: data_out = status;
      8'h02: data_out = inten;
      8'h04, 8'h05, 8'h06, 8'h07: data_out = 8'(32'(period) >> {addr[1:0], 3'b000});
      8'h08, 8'h09, 8'h0A, 8'h0B: data_out = 8'(32'(count_snap) >> {addr[1:0], 3'b000});
      default: begin
        for (int unsigned c = 0; c < N_CH; c++) begin
          if (ch_sel && ch_idx == 4'(c)) begin
            case (addr[3:0])
              4'h0, 4'h1, 4'h2, 4'h3: data_out = 8'(32'(cmp[c]) >> {addr[1:0], 3'b000});
              4'h4:    data_out = tx_slot[c];
              4'h5:    data_out = rx_slot[c];
              4'h6:    data_out = {7'b0, ch_en[c]};
              default: data_out = '0;
            endcase
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_tpu_mc.sv
// Directed bench for tpu_mc: expected values are queued as stimulus is applied
// and popped against register reads and clock/interrupt outputs.
module tb_tpu_mc;
  logic       sys_clock = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [3:0] g_clk_tx, g_clk_rx;
  logic       tpu_int;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  tpu_mc #(.CNT_W(16), .N_CH(4)) dut (
    .sys_clock(sys_clock), .reset(reset), .valid(valid), .addr(addr),
    .data_in(data_in), .data_out(data_out), .g_clk_tx(g_clk_tx),
    .g_clk_rx(g_clk_rx), .tpu_int(tpu_int)
  );

  always #10 sys_clock = ~sys_clock;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty obs=%0h exp=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s obs=%0h exp=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    valid = 1'b1; addr = a; data_in = d;
    @(posedge sys_clock);
    #1;
    valid = 1'b0; addr = 8'h00; data_in = 8'h00;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] e);
    push(tag, {24'b0, e});
    addr = a;
    #1;
    observe({24'b0, data_out});
  endtask

  task automatic out_chk(input string tag, input logic obs, input logic e);
    push(tag, {31'b0, e});
    observe({31'b0, obs});
  endtask

  initial begin
    // reset state: every address reads 0, outputs low
    cyc(2);
    out_chk("rst_tx", |g_clk_tx, 1'b0);
    out_chk("rst_rx", |g_clk_rx, 1'b0);
    out_chk("rst_int", tpu_int, 1'b0);
    for (int a = 0; a < 256; a++) begin
      rd_chk($sformatf("rst_rd_%02h", a), 8'(a), 8'h00);
      if (a % 4 == 3) cyc(1);
    end
    reset = 1'b1;
    cyc(2);

    // compare + wrap + interrupt timing
    wr(8'h04, 8'h03); wr(8'h05, 8'h00);
    wr(8'h10, 8'h02); wr(8'h16, 8'h01);
    wr(8'h02, 8'h81);
    rd_chk("inten_rb", 8'h02, 8'h81);
    rd_chk("cmp0_lo", 8'h10, 8'h02);
    rd_chk("cmp0_b2", 8'h12, 8'h00);
    wr(8'h00, 8'h01);                       // edge 0
    cyc(2);                                 // edge 2
    rd_chk("st_e2", 8'h01, 8'h00);
    cyc(1);                                 // edge 3
    out_chk("int_e3", tpu_int, 1'b0);
    rd_chk("st_e3", 8'h01, 8'h01);
    cyc(1);                                 // edge 4
    out_chk("int_e4", tpu_int, 1'b1);
    rd_chk("st_e4", 8'h01, 8'h81);
    wr(8'h00, 8'h21);                       // edge 5: snap counter 0
    rd_chk("snap_e5_lo", 8'h08, 8'h00);
    rd_chk("snap_e5_hi", 8'h09, 8'h00);
    cyc(1);                                 // edge 6
    wr(8'h01, 8'h01);                       // edge 7: W1C collides with compare
    rd_chk("st_setwins", 8'h01, 8'h81);
    wr(8'h00, 8'h00);                       // edge 8
    wr(8'h01, 8'hFF);                       // edge 9
    out_chk("int_e9", tpu_int, 1'b1);
    rd_chk("st_clr", 8'h01, 8'h00);
    cyc(1);
    out_chk("int_fall", tpu_int, 1'b0);

    // channel 1 dividers: TX_SLOT=1, RX_SLOT=0, tick every 2 cycles
    wr(8'h24, 8'h01); wr(8'h25, 8'h00); wr(8'h26, 8'h01);
    for (int k = 1; k <= 13; k++) begin
      push($sformatf("tx1_k%0d", k), {31'b0, 1'(k >= 4 && ((k - 4) % 8) < 4)});
      push($sformatf("rx1_k%0d", k), {31'b0, 1'((k >> 1) & 1)});
    end
    wr(8'h00, 8'h05);                       // edge T
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      observe({31'b0, g_clk_tx[1]});
      observe({31'b0, g_clk_rx[1]});
    end
    wr(8'h26, 8'h00);                       // edge T+14
    cyc(1);
    out_chk("tx1_off", g_clk_tx[1], 1'b0);
    out_chk("rx1_off", g_clk_rx[1], 1'b0);
    cyc(1);
    out_chk("tx1_off2", g_clk_tx[1], 1'b0);

    // oneshot: single wrap, EN drops, counter held at 0
    wr(8'h00, 8'h02);
    rd_chk("srst_st", 8'h01, 8'h00);
    wr(8'h04, 8'h05);
    wr(8'h00, 8'h11);
    cyc(10);
    rd_chk("os_ctrl", 8'h00, 8'h10);
    rd_chk("os_st", 8'h01, 8'h81);
    wr(8'h01, 8'hFF);
    cyc(8);
    rd_chk("os_nowrap", 8'h01, 8'h00);
    wr(8'h00, 8'h30);
    rd_chk("os_cnt_lo", 8'h08, 8'h00);
    rd_chk("os_cnt_hi", 8'h09, 8'h00);

    // byte ranges and unmapped addresses
    wr(8'h04, 8'h00); wr(8'h05, 8'h03); wr(8'h06, 8'hAA);
    rd_chk("per_b2", 8'h06, 8'h00);
    rd_chk("per_hi", 8'h05, 8'h03);
    wr(8'h50, 8'h77);
    rd_chk("unmap_ch", 8'h50, 8'h00);
    rd_chk("unmap_03", 8'h03, 8'h00);

    // snapshot of running counter, stable afterwards
    wr(8'h00, 8'h01);                       // edge R
    cyc(99);                                // counter = 99
    wr(8'h00, 8'h21);
    rd_chk("snap_lo", 8'h08, 8'h63);
    rd_chk("snap_hi", 8'h09, 8'h00);
    cyc(10);
    rd_chk("snap_hold", 8'h08, 8'h63);

    // SRST with EN=1: SRST wins, PERIOD preserved
    wr(8'h00, 8'h03);
    rd_chk("srst_ctrl", 8'h00, 8'h00);
    rd_chk("srst_st2", 8'h01, 8'h00);
    rd_chk("srst_per_lo", 8'h04, 8'h00);
    rd_chk("srst_per_hi", 8'h05, 8'h03);
    rd_chk("srst_cmp0", 8'h10, 8'h02);
    cyc(5);
    out_chk("srst_int", tpu_int, 1'b0);
    wr(8'h00, 8'h20);
    rd_chk("srst_cnt_lo", 8'h08, 8'h00);
    rd_chk("srst_cnt_hi", 8'h09, 8'h00);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover obs=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tpu_mc.md
# tpu_mc

Multi-channel, parametrised Time Processing Unit: one shared prescaled period counter drives N_CH independent channels, each with its own compare interrupt and TX/RX modulation clock divider. Configuration and status sit behind the same 8-bit register bus used on the AMBA side (valid/addr/data_in/data_out). It is the drop-in successor of the single-channel TPU for designs that need several BSG/BD channels sharing one timebase.

## Interface
Parameters:
- CNT_W, 16, counter/period/compare width; one of 8, 16, 24, 32
- N_CH, 4, number of channels, 1..7

Ports:
- sys_clock  in  1  bus clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- valid  in  1  write strobe; write happens on the sys_clock edge where valid=1
- addr  in  8  register address
- data_in  in  8  write data
- data_out  out  8  read data, combinational mux of the register at addr
- g_clk_tx  out  N_CH  per-channel modulation clock (BSG)
- g_clk_rx  out  N_CH  per-channel demodulation clock (BD)
- tpu_int  out  1  registered interrupt, level-high

## Operation
- Register map (B = CNT_W/8; bytes at index ≥B read 0, writes ignored; unmapped addresses read 0):
  - 0x00 CTRL: [0] EN, [1] SRST (self-clearing, reads 0), [3:2] PRESC (tick every 1/2/4/8 cycles), [4] ONESHOT, [5] SNAP (self-clearing, reads 0)
  - 0x01 STATUS: [N_CH-1:0] compare flags, [7] wrap flag; write-1-to-clear
  - 0x02 INTEN: same bit layout as STATUS
  - 0x04..0x07 PERIOD bytes, little-endian; 0x08..0x0B COUNT snapshot (read-only)
  - Channel c at 0x10+0x10*c: +0..+3 CMP bytes, +4 TX_SLOT, +5 RX_SLOT, +6 CH_CTRL ([0] CH_EN)
- Prescaler: 3-bit counter runs while EN=1; tick = EN && (presc_cnt & mask)==mask, mask = 0,1,3,7 per PRESC. EN=0 clears prescaler.
- Counter: on tick, if counter==PERIOD then counter←0, STATUS[7]←1, and if ONESHOT then EN←0; else counter+1. PERIOD=0: counter stays 0, wrap flag sets every tick. Writing EN=0 holds counter value.
- Compare: on tick with CH_EN[c]=1 and counter==CMP[c] (pre-increment value), STATUS[c]←1.
- Clock dividers: per channel, 8-bit tx/rx dividers advance on tick while CH_EN=1; when divider==TX_SLOT (resp. RX_SLOT), divider←0 and g_clk_tx[c] (resp. rx) toggles. Output period = 2*(SLOT+1) ticks. CH_EN=0: divider and output held 0.
- SNAP: copies counter into COUNT shadow on the write edge.
- SRST: on the write edge clears counter, prescaler, dividers, clock outputs, STATUS, EN; PERIOD/CMP/SLOT/INTEN/CH_EN preserved.
- tpu_int ← |(STATUS & INTEN), registered.

## Timing
- Reset: all registers 0, counter 0, g_clk_tx/g_clk_rx 0, tpu_int 0, data_out 0.
- Register writes take effect at the valid edge; EN written at edge t → first increment at edge t+1 (PRESC=0).
- Flag set at tick edge; tpu_int rises one edge later; falls one edge after W1C or INTEN clear.
- Set and W1C of same STATUS bit on same edge: set wins.
- Write to CTRL with EN=1 and SRST=1 together: SRST wins, EN ends 0.
- PERIOD written below current counter: counter keeps incrementing to 2^CNT_W-1, wraps to 0 through natural overflow (wrap flag set only on ==PERIOD).
- reset deassertion mid-operation is not special: registers restart from reset values.

## Test plan
- Reset low → all outputs 0, every addr reads 0x00 except unmapped also 0x00.
- PERIOD=3, CMP0=2, CH_EN0=1, INTEN=0x81, EN=1 at edge 0 → STATUS[0] set edge 3, tpu_int high edge 4, STATUS[7] set edge 4, counter 0 at edge 4.
- Write STATUS=0x01 on same edge compare matches again → bit stays 1; later W1C alone → tpu_int low next edge.
- TX_SLOT=1, PRESC=1 (div 2), CH_EN1=1 → g_clk_tx[1] period 8 cycles; CH_EN1=0 → output 0 next edge.
- ONESHOT=1, PERIOD=5 → single wrap, EN reads 0 afterwards, counter 0 held.
- Counter running, SNAP write → COUNT bytes equal counter at that edge and stay stable; SRST write → counter/STATUS 0, PERIOD unchanged.
